branch_compare_unit: RTL and testbench

- Registered, parametrised successor to the ID-stage equality comparer in the MIPS/DLX pipeline.
- Resolves all conditional-branch conditions: EQ, NE, LTZ, GEZ, GTZ, LEZ, signed LT and unsigned LT.
- Stalls while forwarded operands are not yet available and holds each result until the fetch/PC logic consumes it.
- Keeps saturating counters of resolved branches and taken branches for performance monitoring.

---
 rtl/branch_compare_unit.sv | 205 ++++++++++++++++++++
 tb/tb_branch_compare_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_compare_unit.sv
// Registered branch-condition resolver for the ID stage. It stalls on unforwarded
// operands, holds each result until the fetch/PC logic consumes it, and keeps
// saturating statistics of resolved and taken branches.
module branch_compare_unit #(
    parameter int BUS_SIZE  = 32,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          mode,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic                a_rdy,
    input  logic                b_rdy,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                cmp_out,
    output logic                eq_out,
    output logic [TAG_W-1:0]    out_tag,
    output logic                stall,
    output logic                stall_err,
    output logic [CNT_W-1:0]    total_cnt,
    output logic [CNT_W-1:0]    taken_cnt
);

    localparam int SC_W = $clog2(MAX_STALL + 2);
    localparam logic [SC_W-1:0]  SC_SAT  = SC_W'(MAX_STALL + 1);
    localparam logic [SC_W-1:0]  SC_LIM  = SC_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [SC_W-1:0]     stall_cnt_r;
    logic [SC_W-1:0]     stall_cnt_s;
    logic                out_valid_r;
    logic                cmp_out_r;
    logic                eq_out_r;
    logic [TAG_W-1:0]    out_tag_r;
    logic                stall_r;
    logic                stall_err_r;
    logic [CNT_W-1:0]    total_cnt_r;
    logic [CNT_W-1:0]    taken_cnt_r;
    logic                b_unused_s;
    logic                ops_ok_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                handshake_s;

    // Evaluate the branch condition selected by mode; the zero-compare modes use a only.
    function automatic logic eval_cond(input logic [2:0] m,
                                       input logic [BUS_SIZE-1:0] x,
                                       input logic [BUS_SIZE-1:0] y);
        logic r;
        logic x_zero;
        x_zero = (x == {BUS_SIZE{1'b0}});
        case (m)
            3'b000:  r = (x == y);
            3'b001:  r = (x != y);
            3'b010:  r = x[BUS_SIZE-1];
            3'b011:  r = ~x[BUS_SIZE-1];
            3'b100:  r = ~x[BUS_SIZE-1] & ~x_zero;
            3'b101:  r = x[BUS_SIZE-1] | x_zero;
            3'b110:  r = ($signed(x) < $signed(y));
            3'b111:  r = (x < y);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Handshake qualifiers; in_ready is held low during reset so every output reads 0.
    always_comb begin
        b_unused_s  = (mode >= 3'b010) && (mode <= 3'b101);
        ops_ok_s    = a_rdy & (b_rdy | b_unused_s);
        in_ready_s  = rst_n & ~flush & (~out_valid_r | out_ready);
        accept_s    = in_valid & in_ready_s & ops_ok_s;
        handshake_s = out_valid_r & out_ready & ~flush;
    end

    // Next-state selection; flush overrides everything and returns to IDLE.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_s = ST_RESULT;
                    end else if (in_valid & ~ops_ok_s) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (accept_s) begin
                        state_s = ST_RESULT;
                    end else if (~in_valid) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_RESULT: begin
                    if (accept_s) begin
                        state_s = ST_RESULT;
                    end else if (out_ready) begin
                        if (in_valid & ~ops_ok_s) begin
                            state_s = ST_WAIT;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_RESULT;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Stall cycle count: starts at 1 on entering WAIT, saturates, clears whenever WAIT is left.
    always_comb begin
        stall_cnt_s = {SC_W{1'b0}};
        if (state_s == ST_WAIT) begin
            if (state_r != ST_WAIT) begin
                stall_cnt_s = SC_W'(1);
            end else if (stall_cnt_r == SC_SAT) begin
                stall_cnt_s = SC_SAT;
            end else begin
                stall_cnt_s = stall_cnt_r + SC_W'(1);
            end
        end else begin
            stall_cnt_s = {SC_W{1'b0}};
        end
    end

    // Control state and the status flags decoded from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            stall_cnt_r <= {SC_W{1'b0}};
            out_valid_r <= 1'b0;
            stall_r     <= 1'b0;
            stall_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            stall_cnt_r <= stall_cnt_s;
            out_valid_r <= (state_s == ST_RESULT);
            stall_r     <= (state_s == ST_WAIT);
            stall_err_r <= (stall_cnt_s > SC_LIM);
        end
    end

    // Result fields load only on accept so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_out_r <= 1'b0;
            eq_out_r  <= 1'b0;
            out_tag_r <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            cmp_out_r <= eval_cond(mode, a, b);
            eq_out_r  <= (a == b);
            out_tag_r <= in_tag;
        end
    end

    // Saturating statistics, advanced on each consumed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt_r <= {CNT_W{1'b0}};
            taken_cnt_r <= {CNT_W{1'b0}};
        end else if (handshake_s) begin
            if (total_cnt_r != CNT_SAT) begin
                total_cnt_r <= total_cnt_r + CNT_W'(1);
            end
            if (cmp_out_r && (taken_cnt_r != CNT_SAT)) begin
                taken_cnt_r <= taken_cnt_r + CNT_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign cmp_out   = cmp_out_r;
    assign eq_out    = eq_out_r;
    assign out_tag   = out_tag_r;
    assign stall     = stall_r;
    assign stall_err = stall_err_r;
    assign total_cnt = total_cnt_r;
    assign taken_cnt = taken_cnt_r;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Directed bench for branch_compare_unit: a cycle model built from the branch
// rules is compared every cycle, plus hand-computed literal expectations.
module tb_branch_compare_unit;

    localparam int MS = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        a_rdy = 1'b1;
    logic        b_rdy = 1'b1;
    logic [7:0]  in_tag = 8'd0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, cmp_out, eq_out, stall, stall_err;
    logic [7:0]  out_tag;
    logic [15:0] total_cnt, taken_cnt;
    logic        in_ready2, out_valid2, cmp_out2, eq_out2, stall2, stall_err2;
    logic [7:0]  out_tag2;
    logic [1:0]  total_cnt2, taken_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_compare_unit #(.BUS_SIZE(32), .TAG_W(8), .CNT_W(16), .MAX_STALL(MS)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .a_rdy(a_rdy), .b_rdy(b_rdy), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .cmp_out(cmp_out), .eq_out(eq_out),
        .out_tag(out_tag), .stall(stall), .stall_err(stall_err),
        .total_cnt(total_cnt), .taken_cnt(taken_cnt));

    branch_compare_unit #(.BUS_SIZE(32), .TAG_W(8), .CNT_W(2), .MAX_STALL(MS)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .mode(mode), .a(a), .b(b), .a_rdy(a_rdy), .b_rdy(b_rdy), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready), .cmp_out(cmp_out2), .eq_out(eq_out2),
        .out_tag(out_tag2), .stall(stall2), .stall_err(stall_err2),
        .total_cnt(total_cnt2), .taken_cnt(taken_cnt2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Branch rules evaluated with plain signed/unsigned 64-bit arithmetic.
    function automatic bit cond(input bit [2:0] m, input bit [31:0] x, input bit [31:0] y);
        longint sx, sy, ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (m)
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd2:    return sx < 0;
            3'd3:    return sx >= 0;
            3'd4:    return sx > 0;
            3'd5:    return sx <= 0;
            3'd6:    return sx < sy;
            default: return ux < uy;
        endcase
    endfunction

    function automatic longint cap(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    bit       m_valid, m_cmp, m_eq, m_wait;
    bit [7:0] m_tag;
    int       m_wcnt, m_total, m_taken;
    bit       m_ops, m_rdy, m_hs, m_acc;

    // Model advances on each edge, then the DUT outputs are compared 1 time unit later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_cmp = 1'b0; m_eq = 1'b0; m_wait = 1'b0;
            m_tag = 8'd0; m_wcnt = 0; m_total = 0; m_taken = 0;
        end else begin
            m_ops = a_rdy && (b_rdy || (mode >= 3'd2 && mode <= 3'd5));
            m_rdy = !m_valid || out_ready;
            m_hs  = m_valid && out_ready && !flush;
            m_acc = in_valid && m_rdy && m_ops && !flush;
            if (m_hs) begin
                m_total++;
                m_taken += int'(m_cmp);
            end
            if (flush) begin
                m_valid = 1'b0; m_wait = 1'b0; m_wcnt = 0;
            end else if (m_acc) begin
                m_valid = 1'b1; m_cmp = cond(mode, a, b); m_eq = (a == b); m_tag = in_tag;
                m_wait = 1'b0; m_wcnt = 0;
            end else begin
                if (m_hs) m_valid = 1'b0;
                if (in_valid && m_rdy && !m_ops) begin
                    m_wcnt = m_wait ? int'(cap(m_wcnt + 1, MS + 1)) : 1;
                    m_wait = 1'b1;
                end else begin
                    m_wait = 1'b0; m_wcnt = 0;
                end
            end
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("in_ready", in_ready, rst_n && !flush && (!m_valid || out_ready));
        chk("stall", stall, m_wait);
        chk("stall_err", stall_err, m_wcnt > MS);
        chk("total_cnt", total_cnt, cap(m_total, 65535));
        chk("taken_cnt", taken_cnt, cap(m_taken, 65535));
        chk("total_cnt2", total_cnt2, cap(m_total, 3));
        chk("taken_cnt2", taken_cnt2, cap(m_taken, 3));
        if (m_valid) begin
            chk("cmp_out", cmp_out, m_cmp);
            chk("eq_out", eq_out, m_eq);
            chk("out_tag", out_tag, m_tag);
        end
    end

    task automatic run_one(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y,
                           output logic c);
        in_valid = 1'b1; mode = m; a = x; b = y; in_tag = {5'd0, m};
        cyc();
        c = cmp_out;
        in_valid = 1'b0;
        cyc();
    endtask

    logic [31:0] av [6] = '{32'h0, 32'h8000_0000, 32'h5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h3};
    logic [31:0] bv [6] = '{32'h0, 32'h1, 32'h5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFE};
    logic        res;
    logic [15:0] saved;

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_cmp_tag", {cmp_out, eq_out, out_tag}, 10'd0);
        chk("rst_cnt", {total_cnt, taken_cnt, stall, stall_err}, 34'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // EQ taken, 1-cycle latency, statistics after handshake.
        in_valid = 1'b1; mode = 3'b000; a = 32'h1234; b = 32'h1234; in_tag = 8'h5A;
        cyc();
        chk("eq_valid", out_valid, 1'b1);
        chk("eq_fields", {cmp_out, eq_out, out_tag}, {2'b11, 8'h5A});
        in_valid = 1'b0;
        cyc();
        chk("eq_total", total_cnt, 16'd1);
        chk("eq_taken", taken_cnt, 16'd1);

        run_one(3'b110, 32'hFFFF_FFFF, 32'h1, res); chk("lt_signed", res, 1'b1);
        run_one(3'b111, 32'hFFFF_FFFF, 32'h1, res); chk("ltu", res, 1'b0);
        run_one(3'b100, 32'h0, 32'h5, res);         chk("gtz_zero", res, 1'b0);
        run_one(3'b101, 32'h0, 32'h5, res);         chk("lez_zero", res, 1'b1);

        // Back-to-back sweep over all modes, checked by the model.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; mode = 3'(i); a = av[i % 6]; b = bv[i % 6]; in_tag = 8'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc(); cyc();

        // Stall on b for 3 cycles.
        in_valid = 1'b1; mode = 3'b000; a = 32'd7; b = 32'd7; b_rdy = 1'b0; in_tag = 8'h33;
        cyc(); chk("stall_c1", stall, 1'b1);
        cyc(); chk("stall_c2", stall, 1'b1);
        cyc(); chk("stall_c3", stall, 1'b1);
        chk("stall_no_valid", out_valid, 1'b0);
        b_rdy = 1'b1;
        cyc();
        chk("stall_released", {stall, out_valid, out_tag}, {2'b01, 8'h33});
        in_valid = 1'b0;
        cyc();

        // LTZ ignores b_rdy.
        in_valid = 1'b1; mode = 3'b010; a = 32'h8000_0000; b_rdy = 1'b0;
        cyc();
        chk("ltz_nostall", {stall, out_valid, cmp_out}, 3'b011);
        in_valid = 1'b0; b_rdy = 1'b1;
        cyc();

        // Stall timeout.
        in_valid = 1'b1; mode = 3'b000; a = 32'd9; b = 32'd9; a_rdy = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            chk("stall_err_t", stall_err, k >= 16);
        end
        a_rdy = 1'b1;
        cyc();
        chk("stall_err_clr", {stall_err, out_valid}, 2'b01);
        in_valid = 1'b0;
        cyc();

        // Backpressure with a second request pending.
        in_valid = 1'b1; mode = 3'b000; a = 32'd1; b = 32'd1; in_tag = 8'h11; out_ready = 1'b0;
        cyc();
        saved = total_cnt;
        mode = 3'b110; a = 32'd1; b = 32'd2; in_tag = 8'h22;
        for (int k = 0; k < 4; k++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_hold", {out_valid, cmp_out, out_tag}, {2'b11, 8'h11});
            chk("bp_cnt", total_cnt, saved);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_second", {out_valid, cmp_out, out_tag}, {2'b11, 8'h22});
        chk("bp_cnt1", total_cnt, saved + 16'd1);
        in_valid = 1'b0;
        cyc();
        chk("bp_cnt2", total_cnt, saved + 16'd2);

        // Flush together with a handshake.
        in_valid = 1'b1; mode = 3'b001; a = 32'd1; b = 32'd2; in_tag = 8'h44;
        cyc();
        saved = total_cnt;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        cyc();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_cnt", total_cnt, saved);
        flush = 1'b0; in_valid = 1'b0;
        cyc();
        chk("flush_dropped", {out_valid, total_cnt}, {1'b0, saved});

        // Asynchronous reset while waiting.
        in_valid = 1'b1; mode = 3'b000; a_rdy = 1'b0;
        cyc(); cyc();
        chk("wait_before_rst", stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flags", {stall, stall_err, out_valid, in_ready}, 4'd0);
        chk("arst_cnt", {total_cnt, taken_cnt}, 32'd0);
        cyc();
        rst_n = 1'b1; in_valid = 1'b0; a_rdy = 1'b1;
        cyc();

        // Five taken branches saturate the 2-bit counters.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; mode = 3'b000; a = 32'd4; b = 32'd4; in_tag = 8'(k);
            cyc();
        end
        in_valid = 1'b0;
        cyc(); cyc();
        chk("taken5", taken_cnt, 16'd5);
        chk("taken_sat", taken_cnt2, 2'd3);
        chk("total_sat", total_cnt2, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
